// File: rtl/sample_ingest_fifo_if.sv
// ADC-to-filter sample interface: upstream strobe/data/ready plus the filter-side
// Din/Hlt outputs and the status and control lines of the ingest FIFO.
interface sample_ingest_fifo_if #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 12
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic             adc_valid;
    logic [WIDTH-1:0] adc_data;
    logic             adc_ready;
    logic             enable;
    logic             ovf_clr;
    logic [WIDTH-1:0] din;
    logic             hlt;
    logic             ovf;
    logic [LW-1:0]    level;

    modport master (
        output adc_valid, adc_data, enable, ovf_clr,
        input  adc_ready, din, hlt, ovf, level
    );

    modport slave (
        input  adc_valid, adc_data, enable, ovf_clr,
        output adc_ready, din, hlt, ovf, level
    );
endinterface

// File: rtl/sample_ingest_fifo.sv
// Elastic buffer between the ADC sample strobe and the filter Din/Hlt port.
// There is no empty-bypass and no full-bypass; Hlt drops for one cycle per popped sample.
module sample_ingest_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 12
) (
    input logic               clk,
    input logic               rst_n,
    sample_ingest_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level;
    logic [WIDTH-1:0] din;
    logic             hlt;
    logic             ovf;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             drop;

    always_comb begin
        full  = (level == LW'(DEPTH));
        empty = (level == '0);
        push  = bus.adc_valid && !full;
        drop  = bus.adc_valid && full;
        pop   = bus.enable && !empty;
    end

    // Storage is never reset; the level count ensures only written entries are read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.adc_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            din    <= '0;
            hlt    <= 1'b1;
            ovf    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                din    <= mem[rd_ptr];
                rd_ptr <= rd_ptr + AW'(1);
                hlt    <= 1'b0;
            end else begin
                hlt    <= 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            // A drop on the same edge as a clear keeps the flag set.
            if (drop) begin
                ovf <= 1'b1;
            end else if (bus.ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

    assign bus.adc_ready = !full;
    assign bus.din       = din;
    assign bus.hlt       = hlt;
    assign bus.ovf       = ovf;
    assign bus.level     = level;
endmodule

// File: tb/tb_sample_ingest_fifo.sv
// Self-checking bench for sample_ingest_fifo: directed scenarios plus a random run,
// all checked against a queue-based model of the buffer.
module tb_sample_ingest_fifo;
    localparam int DEPTH = 8;
    localparam int WIDTH = 12;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    sample_ingest_fifo_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    sample_ingest_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_din;
    logic             m_hlt;
    logic             m_ovf;
    logic [LW-1:0]    m_level;

    task automatic model_reset();
        q.delete();
        m_din   = '0;
        m_hlt   = 1'b1;
        m_ovf   = 1'b0;
        m_level = '0;
    endtask

    // Drive one cycle of inputs, advance the model by the buffer rules, then sample after the edge.
    task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic en, input logic clr);
        bit was_full;
        bit do_pop;
        bus.adc_valid = v;
        bus.adc_data  = d;
        bus.enable    = en;
        bus.ovf_clr   = clr;
        was_full = (q.size() == DEPTH);
        do_pop   = en && (q.size() > 0);
        if (do_pop) begin
            m_din = q.pop_front();
            m_hlt = 1'b0;
        end else begin
            m_hlt = 1'b1;
        end
        if (v && !was_full) q.push_back(d);
        if (v && was_full) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        m_level = LW'(q.size());
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.adc_valid = 1'b0;
        bus.adc_data  = '0;
        bus.enable    = 1'b0;
        bus.ovf_clr   = 1'b0;
        model_reset();
        #12;
        total++; if (bus.level !== '0) begin bad++; $display("FAIL reset_level got=%0d exp=0", bus.level); end
        total++; if (bus.hlt !== 1'b1) begin bad++; $display("FAIL reset_hlt got=%b exp=1", bus.hlt); end
        total++; if (bus.din !== '0) begin bad++; $display("FAIL reset_din got=%h exp=0", bus.din); end
        total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", bus.ovf); end
        total++; if (bus.adc_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", bus.adc_ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_latency();
        step(1'b1, 12'h123, 1'b1, 1'b0);
        total++; if (bus.hlt !== 1'b1) begin bad++; $display("FAIL lat_no_bypass hlt got=%b exp=1", bus.hlt); end
        total++; if (bus.level !== LW'(1)) begin bad++; $display("FAIL lat_level got=%0d exp=1", bus.level); end
        step(1'b0, '0, 1'b1, 1'b0);
        total++; if (bus.din !== 12'h123 || bus.hlt !== 1'b0) begin bad++; $display("FAIL lat_out got din=%h hlt=%b exp din=123 hlt=0", bus.din, bus.hlt); end
        step(1'b0, '0, 1'b1, 1'b0);
        total++; if (bus.din !== 12'h123 || bus.hlt !== 1'b1) begin bad++; $display("FAIL lat_hold got din=%h hlt=%b exp din=123 hlt=1", bus.din, bus.hlt); end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 40; i++) begin
            step(1'b1, WIDTH'(12'h200 + i), 1'b1, 1'b0);
            total++; if (bus.level !== LW'(1)) begin bad++; $display("FAIL stream_level i=%0d got=%0d exp=1", i, bus.level); end
            total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL stream_ovf i=%0d got=%b exp=0", i, bus.ovf); end
            if (i > 0) begin
                total++;
                if (bus.din !== WIDTH'(12'h200 + i - 1) || bus.hlt !== 1'b0) begin
                    bad++; $display("FAIL stream_din i=%0d got=%h hlt=%b exp=%h hlt=0", i, bus.din, bus.hlt, WIDTH'(12'h200 + i - 1));
                end
            end
        end
        step(1'b0, '0, 1'b1, 1'b0);
        total++; if (bus.din !== 12'h227 || bus.level !== '0) begin bad++; $display("FAIL stream_tail got din=%h lvl=%0d exp din=227 lvl=0", bus.din, bus.level); end
    endtask

    task automatic test_enable_gating();
        for (int i = 0; i < 3; i++) step(1'b1, WIDTH'(12'h050 + i), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, '0, 1'b0, 1'b0);
            total++; if (bus.hlt !== 1'b1 || bus.level !== LW'(3)) begin bad++; $display("FAIL gate_hold i=%0d got hlt=%b lvl=%0d exp hlt=1 lvl=3", i, bus.hlt, bus.level); end
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            total++; if (bus.hlt !== 1'b0 || bus.din !== WIDTH'(12'h050 + i)) begin bad++; $display("FAIL gate_pop i=%0d got din=%h hlt=%b exp din=%h hlt=0", i, bus.din, bus.hlt, WIDTH'(12'h050 + i)); end
        end
        step(1'b0, '0, 1'b1, 1'b0);
        total++; if (bus.hlt !== 1'b1 || bus.level !== '0) begin bad++; $display("FAIL gate_end got hlt=%b lvl=%0d exp hlt=1 lvl=0", bus.hlt, bus.level); end
    endtask

    task automatic test_fill_overflow();
        for (int i = 1; i <= 9; i++) begin
            step(1'b1, WIDTH'(i), 1'b0, 1'b0);
            if (i == 8) begin
                total++; if (bus.level !== LW'(8) || bus.adc_ready !== 1'b0) begin bad++; $display("FAIL fill_full got lvl=%0d rdy=%b exp lvl=8 rdy=0", bus.level, bus.adc_ready); end
                total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL fill_ovf_early got=%b exp=0", bus.ovf); end
            end
        end
        total++; if (bus.ovf !== 1'b1 || bus.level !== LW'(8)) begin bad++; $display("FAIL fill_drop got ovf=%b lvl=%0d exp ovf=1 lvl=8", bus.ovf, bus.level); end
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            total++; if (bus.din !== WIDTH'(i) || bus.hlt !== 1'b0) begin bad++; $display("FAIL fill_drain i=%0d got din=%h hlt=%b exp din=%h hlt=0", i, bus.din, bus.hlt, WIDTH'(i)); end
        end
        step(1'b0, '0, 1'b1, 1'b0);
        total++; if (bus.hlt !== 1'b1 || bus.din !== WIDTH'(8)) begin bad++; $display("FAIL fill_after got hlt=%b din=%h exp hlt=1 din=008", bus.hlt, bus.din); end
    endtask

    task automatic test_ovf_priority();
        step(1'b0, '0, 1'b0, 1'b1);
        total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL ovf_clear0 got=%b exp=0", bus.ovf); end
        for (int i = 0; i < DEPTH; i++) step(1'b1, WIDTH'($urandom), 1'b0, 1'b0);
        step(1'b1, WIDTH'($urandom), 1'b0, 1'b1);
        total++; if (bus.ovf !== 1'b1 || bus.level !== LW'(8)) begin bad++; $display("FAIL ovf_set_wins got ovf=%b lvl=%0d exp ovf=1 lvl=8", bus.ovf, bus.level); end
        step(1'b0, '0, 1'b0, 1'b1);
        total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", bus.ovf); end
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            total++; if (bus.din !== m_din) begin bad++; $display("FAIL ovf_drain i=%0d got=%h exp=%h", i, bus.din, m_din); end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) step(1'b1, WIDTH'(12'h300 + i), 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        bus.adc_valid = 1'b0;
        bus.enable    = 1'b1;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        total++; if (bus.level !== '0 || bus.hlt !== 1'b1 || bus.din !== '0 || bus.adc_ready !== 1'b1) begin
            bad++; $display("FAIL midrst got lvl=%0d hlt=%b din=%h rdy=%b exp 0/1/0/1", bus.level, bus.hlt, bus.din, bus.adc_ready);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 12'h0AA, 1'b1, 1'b0);
        total++; if (bus.din !== '0 || bus.hlt !== 1'b1) begin bad++; $display("FAIL midrst_stale got din=%h hlt=%b exp din=000 hlt=1", bus.din, bus.hlt); end
        step(1'b0, '0, 1'b1, 1'b0);
        total++; if (bus.din !== 12'h0AA || bus.hlt !== 1'b0) begin bad++; $display("FAIL midrst_first got din=%h hlt=%b exp din=0aa hlt=0", bus.din, bus.hlt); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 60), WIDTH'($urandom), ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 10));
            total++;
            if (bus.din !== m_din || bus.hlt !== m_hlt || bus.ovf !== m_ovf || bus.level !== m_level || bus.adc_ready !== (m_level != LW'(DEPTH))) begin
                bad++;
                $display("FAIL rand i=%0d got din=%h hlt=%b ovf=%b lvl=%0d rdy=%b exp din=%h hlt=%b ovf=%b lvl=%0d",
                         i, bus.din, bus.hlt, bus.ovf, bus.level, bus.adc_ready, m_din, m_hlt, m_ovf, m_level);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_latency();
        test_stream();
        test_enable_gating();
        test_fill_overflow();
        test_ovf_priority();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sample_ingest_fifo.md
SAMPLE_INGEST_FIFO -- requirements
Module: sample_ingest_fifo

Interface
REQ-001 The block SHALL take parameter DEPTH, default 8, meaning FIFO entries; legal values are powers of two, 4..64.
REQ-002 The block SHALL take parameter WIDTH, default 12, meaning the sample width, matching the filter's Din width.
REQ-003 Clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 Rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Adc_valid  input  1  upstream ADC sample strobe.
REQ-006 Adc_data  input  WIDTH  upstream sample, unsigned, sampled when Adc_valid=1.
REQ-007 Adc_ready  output  1  combinational, equals (Level != DEPTH).
REQ-008 Enable  input  1  1 = forward samples to the filter; 0 = freeze the filter.
REQ-009 Ovf_clr  input  1  synchronous clear of Ovf.
REQ-010 Din  output  WIDTH  registered sample to the filter Din port.
REQ-011 Hlt  output  1  registered halt to the filter Hlt port; 1 = filter must not advance.
REQ-012 Ovf  output  1  sticky overflow flag.
REQ-013 Level  output  log2(DEPTH)+1  registered current occupancy, 0..DEPTH.

Function
REQ-014 Push: when Adc_valid=1 and Level<DEPTH at the edge, the block SHALL write Adc_data at the write pointer and advance that pointer, wrapping from DEPTH-1 to 0.
REQ-015 Drop: when Adc_valid=1 and Level=DEPTH at the edge, the block SHALL discard the sample and set Ovf=1. This applies even if a pop occurs on the same edge; no full-bypass.
REQ-016 Pop: when Enable=1 and Level>0 at the edge, the block SHALL load Din with the entry at the read pointer, set Hlt=0, and advance the read pointer with wrap.
REQ-017 No pop: when Enable=0 or Level=0 at the edge, the block SHALL set Hlt=1 and hold Din at its previous value.
REQ-018 Empty: there SHALL be no empty-bypass. A sample pushed on edge N into an empty FIFO SHALL appear on Din with Hlt=0 after edge N+1, giving a minimum latency of 2 edges from Adc_valid to Din.
REQ-019 Hlt SHALL be 0 for exactly one cycle per popped sample, so the filter advances once per sample.
REQ-020 Level update per edge:
 - push only: +1
 - pop only: -1
 - push and pop together: unchanged
 - dropped push: counts as no push
REQ-021 Level SHALL never exceed DEPTH or go below 0.
REQ-022 When Ovf_clr=1, Ovf SHALL clear on the edge. If a drop occurs on the same edge, set wins and Ovf=1.
REQ-023 Data SHALL pass through unmodified; the block performs no arithmetic on samples.
REQ-024 Samples SHALL leave in strict arrival order across pointer wrap-around.
REQ-025 Enable SHALL affect only popping; pushes continue while Enable=0 until full.

Reset
REQ-026 On Rst_n=0 the block SHALL asynchronously force:
 - Din=0, Hlt=1, Ovf=0, Level=0
 - both pointers=0
 - Adc_ready=1
REQ-027 Reset mid-operation SHALL discard all buffered samples. The first push after release SHALL be the first sample output.
REQ-028 FIFO storage SHALL not require reset, and its contents SHALL never be observable before being written.
REQ-029 Rst_n deassertion SHALL be treated as synchronous to Clk by the integrator. The block SHALL not push or pop on the edge where Rst_n is sampled low.

Verification
REQ-030 Latency: with Enable=1, push 0x123 on one edge into an empty FIFO -> after the next edge Din=0x123 and Hlt=0; the following cycle Hlt=1 and Din=0x123 holds.
REQ-031 Fill/overflow: with Enable=0, push 0x001..0x009 on consecutive edges -> Level=8 and Adc_ready=0 after the 8th push; 0x009 is dropped and Ovf=1; with Enable=1, Din outputs 0x001..0x008 with 8 consecutive Hlt=0 cycles, then Hlt=1.
REQ-032 Steady stream: with Enable=1, Adc_valid=1 every cycle for 40 cycles with an incrementing ramp -> Level stays at 1, Ovf stays 0, Din reproduces the ramp in order across pointer wrap.
REQ-033 Ovf priority: with Level=8, assert Adc_valid=1 and Ovf_clr=1 on the same edge -> Ovf=1. Next edge with Ovf_clr=1 and Adc_valid=0 -> Ovf=0.
REQ-034 Reset mid-op: push 5 samples, assert Rst_n=0 between edges -> immediately Level=0, Hlt=1, Din=0, Adc_ready=1; after release, push 0x0AA -> Din=0x0AA is the first output.
REQ-035 Enable gating: hold 3 samples with Enable=0 for 10 cycles -> Hlt=1 and Level=3 throughout; raise Enable -> 3 pops on consecutive edges, then Hlt=1 and Level=0.
